// File: rtl/mvb_manchester_rx.sv
// mvb_manchester_rx: MVB Manchester line receiver. It does 16x oversampled delimiter detection,
// word decoding and a CRC7/parity check per block. Define MVB_RX_GLITCH_FILTER_EN to add a 3-sample majority filter.
module mvb_manchester_rx #(
    parameter logic [15:0] MDELIM       = 16'hE4B0,
    parameter logic [15:0] SDELIM       = 16'hE1B4,
    parameter int          IDLE_SAMPLES = 32
) (
    input  logic        clk_24M,
    input  logic        rst,
    input  logic        line_in,
    input  logic [4:0]  frame_len,
    output logic [15:0] word_out,
    output logic        word_valid,
    output logic        frame_start,
    output logic        frame_is_master,
    output logic        frame_done,
    output logic        manch_err,
    output logic        delim_err,
    output logic        crc_err,
    output logic        len_err
);
    localparam int IW = $clog2(IDLE_SAMPLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_DELIM, S_DATA, S_CHECK, S_END, S_ERR} state_t;

    logic [1:0]  r_sync;
    logic        w_lvl;
    logic        r_prev;
    logic        w_edge;
    logic [2:0]  r_ph;
    logic        r_hb_v;
    logic        r_hb;

`ifdef MVB_RX_GLITCH_FILTER_EN
    logic [2:0]  r_maj;
    logic        r_lvl;

    always_ff @(posedge clk_24M) begin
        if (!rst) begin
            r_maj <= '0;
            r_lvl <= 1'b0;
        end else begin
            r_maj <= {r_maj[1:0], r_sync[1]};
            r_lvl <= (r_maj[0] & r_maj[1]) | (r_maj[0] & r_maj[2]) | (r_maj[1] & r_maj[2]);
        end
    end
    assign w_lvl = r_lvl;
`else
    assign w_lvl = r_sync[1];
`endif

    assign w_edge = w_lvl ^ r_prev;

    // NOTE: clocked blocks use only <=, so every register sees the pre-edge value of every other.
    always_ff @(posedge clk_24M) begin
        if (!rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_ph   <= 3'd0;
            r_hb_v <= 1'b0;
            r_hb   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], line_in};
            r_prev <= w_lvl;
            r_ph   <= w_edge ? 3'd0 : r_ph + 3'd1;
            r_hb_v <= (r_ph == 3'd3) && !w_edge;
            r_hb   <= w_lvl;
        end
    end

    state_t      r_state;
    logic [14:0] r_hs;
    logic [3:0]  r_hcnt;
    logic [3:0]  r_bcnt;
    logic        r_half;
    logic        r_first;
    logic [14:0] r_word;
    logic [4:0]  r_wcnt;
    logic [4:0]  r_len;
    logic [1:0]  r_blk;
    logic [6:0]  r_crc;
    logic        r_par;
    logic [6:0]  r_chk;
    logic [IW-1:0] r_idle;

    logic [15:0] w_hs_next;
    logic [15:0] w_word_next;
    logic [6:0]  w_crc_next;
    logic        w_pair_bad;

    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic d);
        return {crc[5:0], 1'b0} ^ (((d ^ crc[6]) != 1'b0) ? 7'h65 : 7'h00);
    endfunction

    assign w_hs_next   = {r_hs, r_hb};
    assign w_word_next = {r_word, r_first};
    assign w_crc_next  = crc7_next(r_crc, r_first);
    assign w_pair_bad  = (r_first == r_hb);

    always_ff @(posedge clk_24M) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_hs <= '0;  r_hcnt <= '0;  r_bcnt <= '0;  r_half <= 1'b0;  r_first <= 1'b0;
            r_word <= '0;  r_wcnt <= '0;  r_len <= '0;  r_blk <= '0;
            r_crc <= '0;  r_par <= 1'b0;  r_chk <= '0;  r_idle <= '0;
            word_out <= '0;  word_valid <= 1'b0;  frame_start <= 1'b0;  frame_done <= 1'b0;
            frame_is_master <= 1'b0;
            manch_err <= 1'b0;  delim_err <= 1'b0;  crc_err <= 1'b0;  len_err <= 1'b0;
        end else begin
            word_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            case (r_state)
                S_IDLE: if (w_edge && w_lvl) begin
                    r_state <= S_DELIM;
                    r_hcnt  <= '0;
                end
                S_DELIM: if (r_hb_v) begin
                    r_hs   <= w_hs_next[14:0];
                    r_hcnt <= r_hcnt + 4'd1;
                    if (r_hcnt == 4'd15) begin
                        if (w_hs_next == MDELIM || w_hs_next == SDELIM) begin
                            frame_start     <= 1'b1;
                            frame_is_master <= (w_hs_next == MDELIM);
                            manch_err <= 1'b0;  delim_err <= 1'b0;  crc_err <= 1'b0;  len_err <= 1'b0;
                            r_len  <= frame_len;
                            r_half <= 1'b0;  r_bcnt <= '0;  r_wcnt <= '0;  r_blk <= '0;
                            r_crc  <= '0;    r_par  <= 1'b0;
                            if (frame_len == 5'd0) begin
                                len_err    <= 1'b1;
                                frame_done <= 1'b1;
                                r_idle     <= '0;
                                r_state    <= S_ERR;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end else begin
                            delim_err  <= 1'b1;
                            frame_done <= 1'b1;
                            r_idle     <= '0;
                            r_state    <= S_ERR;
                        end
                    end
                end
                S_DATA: if (r_hb_v) begin
                    r_half <= ~r_half;
                    if (!r_half) begin
                        r_first <= r_hb;
                    end else if (w_pair_bad) begin
                        // A low pair on a word boundary is the line going idle early.
                        if (!r_hb && r_bcnt == 4'd0) len_err <= 1'b1;
                        else                         manch_err <= 1'b1;
                        frame_done <= 1'b1;
                        r_idle     <= '0;
                        r_state    <= S_ERR;
                    end else begin
                        r_word <= w_word_next[14:0];
                        r_crc  <= w_crc_next;
                        r_par  <= r_par ^ r_first;
                        r_bcnt <= r_bcnt + 4'd1;
                        if (r_bcnt == 4'd15) begin
                            word_out   <= w_word_next;
                            word_valid <= 1'b1;
                            r_wcnt     <= r_wcnt + 5'd1;
                            r_blk      <= r_blk + 2'd1;
                            if (r_blk == 2'd3 || r_wcnt + 5'd1 == r_len) r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: if (r_hb_v) begin
                    r_half <= ~r_half;
                    if (!r_half) begin
                        r_first <= r_hb;
                    end else if (w_pair_bad) begin
                        manch_err  <= 1'b1;
                        frame_done <= 1'b1;
                        r_idle     <= '0;
                        r_state    <= S_ERR;
                    end else begin
                        r_chk  <= {r_chk[5:0], r_first};
                        r_bcnt <= r_bcnt + 4'd1;
                        if (r_bcnt == 4'd7) begin
                            if ({r_chk, r_first} != {r_crc, r_par ^ (^r_crc)}) crc_err <= 1'b1;
                            r_crc  <= '0;
                            r_par  <= 1'b0;
                            r_bcnt <= '0;
                            r_hcnt <= '0;
                            r_state <= (r_wcnt < r_len) ? S_DATA : S_END;
                        end
                    end
                end
                S_END: if (r_hb_v) begin
                    if (r_hb) begin
                        len_err    <= 1'b1;
                        frame_done <= 1'b1;
                        r_idle     <= '0;
                        r_state    <= S_ERR;
                    end else if (r_hcnt == 4'd1) begin
                        frame_done <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_hcnt <= r_hcnt + 4'd1;
                    end
                end
                S_ERR: begin
                    if (w_lvl)                                r_idle  <= '0;
                    else if (r_idle == IW'(IDLE_SAMPLES - 1)) r_state <= S_IDLE;
                    else                                      r_idle  <= r_idle + IW'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/mvb_manchester_rx.md
# mvb_manchester_rx

Receive-side line decoder for the MVB Manchester link. It is the counterpart of the frame encoder. It samples the serial line at 24 MHz (16 samples per 1.5 Mbit/s bit, 8 per half-bit) and recognises master and slave start delimiters. It decodes data bits into 16-bit words, checks the 8-bit check sequence after every 64 data bits and at frame end, and reports per-frame status to the frame FIFO/control logic.

## Interface
- MDELIM, 16'hE4B0, master start-delimiter half-bit pattern (start bit + 7 bit-times, MSB first, 1=H, 0=L)
- SDELIM, 16'hE1B4, slave start-delimiter half-bit pattern
- IDLE_SAMPLES, 32, consecutive low samples required before the receiver re-arms after an error
- clk_24M  in  1  sample clock
- rst  in  1  reset, synchronous, active-low
- line_in  in  1  Manchester line, asynchronous; idle level low
- frame_len  in  5  expected data words, 1..16; 0 gives len_err
- word_out  out  16  decoded word, MSB received first
- word_valid  out  1  one-cycle strobe, word_out valid
- frame_start  out  1  one-cycle strobe on delimiter match
- frame_is_master  out  1  1=master, 0=slave; latched at frame_start
- frame_done  out  1  one-cycle strobe, frame ended (good or bad)
- manch_err, delim_err, crc_err, len_err  out  1 each  sticky per frame; cleared at next frame_start

## Operation
- Input: 2-flop synchronizer, then an edge detector on the synchronized level.
- Phase counter ph[2:0]: cleared on every detected transition, otherwise increments and wraps 7→0. A half-bit is sampled when ph==3.
- Half-bit shift register hs[15:0] collects samples.
- States:
  - IDLE: on a rising edge go to DELIM.
  - DELIM: collect 16 half-bits. Match MDELIM → master; match SDELIM → slave; pulse frame_start and go to DATA. No match → delim_err and go to ERR.
  - DATA: each pair of half-bits decodes one bit. HL=1, LH=0. HH or LL sets manch_err and goes to ERR.
  - DATA bookkeeping: bits shift into a word register, and CRC7 (poly x^7+x^6+x^5+x^2+1, init 0, MSB first) updates. After 16 bits, pulse word_valid and increment the word count.
  - DATA exit: after the 4th word of a 64-bit block, or when word count == frame_len, go to CHECK.
  - CHECK: receive 8 bits {crc7[6:0], p}. p is the even parity over the block's data bits plus crc7. A mismatch sets crc_err. Then reset CRC/parity.
  - After CHECK: if word count < frame_len, go back to DATA. Otherwise go to END.
  - END: expect 2 low half-bits (end delimiter). Pass → pulse frame_done and go to IDLE. A high half-bit → len_err and go to ERR (frame longer than frame_len).
  - Premature end: line low for 2 half-bits while in DATA, before frame_len words → len_err and go to ERR.
  - ERR: pulse frame_done once. Wait IDLE_SAMPLES consecutive low samples, then go to IDLE.
- frame_len==0 at delimiter match: set len_err and go to ERR; no words are emitted.
- frame_len is sampled at frame_start; changing it mid-frame has no effect.

## Timing
- All outputs are registered. Reset values:
  - word_out = 0
  - all strobes = 0
  - frame_is_master = 0
  - all error flags = 0
  - state = IDLE
  - ph = 0
- Reset mid-frame aborts immediately. No frame_done is issued.
- Latency: word_valid goes high 2 cycles after the ph==3 sample of the word's last half-bit, plus 2 synchronizer cycles.
- Strobe spacing: word_valid strobes are ≥256 cycles apart within a block. A CHECK byte inserts 128 cycles between blocks.
- Error reporting: error flags assert the cycle after detection, and frame_done follows within 1 cycle of entering ERR.
- frame_done and word_valid never assert in the same cycle. The final word_valid precedes the check byte.
- Transitions arriving at ph 0..2 or 4..7 are treated as realignment; no tolerance error is flagged.

## Configuration
- MVB_RX_GLITCH_FILTER_EN defined: a 3-sample majority filter sits after the synchronizer. Single-sample glitches are suppressed, and all latencies grow by 2 cycles.
- Undefined: the synchronizer output feeds the edge detector directly. A 1-cycle glitch in DATA can realign the phase or cause manch_err.

## Test plan
- Master frame, frame_len=1, data 16'h1111, valid check byte → frame_start, frame_is_master=1, one word_valid with 16'h1111, frame_done, no errors.
- Slave frame, frame_len=5, words 0000..4444 → 5 word_valid in order; two CHECK bytes consumed; crc_err=0.
- Same frame with one data half-pair forced to LL → manch_err=1, frame_done, no further word_valid; the next valid frame decodes cleanly.
- Check byte with its parity bit flipped → all words delivered, crc_err=1 at frame_done.
- Unknown delimiter 16'hFFFF → delim_err=1, frame_done, no frame_start; the receiver re-arms after 32 low samples.
- Line ends after 2 of 3 expected words → len_err=1. With MVB_RX_GLITCH_FILTER_EN, a 1-cycle glitch mid-bit → data unaffected.
